// File: rtl/conv_sequencer_pkg.sv
// Shared encodings and width helpers for the convolver sequencer.
package conv_sequencer_pkg;

    // Values driven on o_state towards the MUX_ARRAY.
    localparam logic [1:0] ST_LOAD  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StFlush,
        StDrain
    } fsm_e;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/conv_sequencer_ctrl_delay_line.sv
// Fixed-depth shift register carrying read-side control to the write side.
module conv_sequencer_ctrl_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_sequencer.sv
// LOAD / RUN / FLUSH / DRAIN sequencer for the line-memory convolver datapath.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned BITS_DATA = 13,
    parameter int unsigned BITS_ADDR = 10,
    parameter int unsigned COLS      = 4,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned CONV_LAT  = 2,
    localparam int unsigned SUB_W    = clog2_min1(N / 2 + 1),
    localparam int unsigned SEL_W    = clog2_min1(N + 2)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [1:0]           o_state,
    output logic [SUB_W-1:0]     o_substate,
    output logic [SEL_W-1:0]     o_memSelect,
    output logic [BITS_ADDR-1:0] o_rdAddr,
    output logic [BITS_ADDR-1:0] o_wrAddr,
    output logic [N+1:0]         o_wrEn,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_done
);

    localparam int unsigned D     = MEM_LAT + CONV_LAT;
    localparam int unsigned DL_W  = 1 + BITS_ADDR + SUB_W;
    localparam int unsigned FL_W  = clog2_min1(D);
    localparam int unsigned LAT_W = clog2_min1(MEM_LAT);

    localparam logic [BITS_ADDR-1:0] LAST_COL       = BITS_ADDR'(COLS - 1);
    localparam logic [SEL_W-1:0]     LAST_LOAD_MEM  = SEL_W'(N + 1);
    localparam logic [SEL_W-1:0]     LAST_DRAIN_MEM = SEL_W'(N - 1);
    localparam logic [SUB_W-1:0]     LAST_SUB       = SUB_W'(N / 2);
    localparam logic [FL_W-1:0]      LAST_FLUSH     = FL_W'(D - 1);
    localparam logic [LAT_W-1:0]     LAST_LAT       = LAT_W'(MEM_LAT - 1);

    // The write outputs are registered after the delay line, so it holds D-1 stages.
    if (N < 2 || (N % 2) != 0 || MEM_LAT < 1 || CONV_LAT < 1 || COLS < 1 ||
        COLS > (2 ** BITS_ADDR) || BITS_DATA < 1) begin : g_param_check
        $error("conv_sequencer: unsupported parameter set");
    end

    fsm_e                 st_q;
    logic [BITS_ADDR-1:0] col_q;
    logic                 issue_q;
    logic [FL_W-1:0]      flush_q;
    logic [LAT_W-1:0]     lat_q;

    logic [DL_W-1:0]      dl_out;
    logic                 dl_issue;
    logic [BITS_ADDR-1:0] dl_addr;
    logic [SUB_W-1:0]     dl_sub;
    logic [N+1:0]         load_onehot;

    conv_sequencer_ctrl_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (D - 1)
    ) u_delay (
        .clk   (i_clock),
        .rst_n (i_reset),
        .din   ({issue_q, o_rdAddr, o_substate}),
        .dout  (dl_out)
    );

    assign {dl_issue, dl_addr, dl_sub} = dl_out;
    assign load_onehot = (N + 2)'(1) << o_memSelect;

    // Substate z writes the N memories that held its input window, rotating by two per step.
    function automatic logic [N+1:0] run_mask(input logic [SUB_W-1:0] z);
        logic [N+1:0] m;
        m = '0;
        for (int x = 0; x < int'(N + 2); x++) begin
            m[x] = ((x + 2 * int'(z)) % int'(N + 2)) < int'(N);
        end
        return m;
    endfunction

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            st_q        <= StIdle;
            col_q       <= '0;
            issue_q     <= 1'b0;
            flush_q     <= '0;
            lat_q       <= '0;
            o_ready     <= 1'b0;
            o_state     <= ST_LOAD;
            o_substate  <= '0;
            o_memSelect <= '0;
            o_rdAddr    <= '0;
            o_wrAddr    <= '0;
            o_wrEn      <= '0;
            o_valid     <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_wrEn <= '0;
            o_done <= 1'b0;
            case (st_q)
                StIdle: begin
                    if (i_start) begin
                        st_q        <= StLoad;
                        o_ready     <= 1'b1;
                        col_q       <= '0;
                        o_memSelect <= '0;
                    end
                end
                StLoad: begin
                    if (i_valid) begin
                        o_wrEn   <= load_onehot;
                        o_wrAddr <= col_q;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (o_memSelect == LAST_LOAD_MEM) begin
                                st_q        <= StRun;
                                o_ready     <= 1'b0;
                                o_state     <= ST_RUN;
                                o_memSelect <= '0;
                                o_substate  <= '0;
                                o_rdAddr    <= '0;
                                issue_q     <= 1'b1;
                            end else begin
                                o_memSelect <= o_memSelect + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StRun: begin
                    o_wrEn   <= dl_issue ? run_mask(dl_sub) : '0;
                    o_wrAddr <= dl_addr;
                    if (o_rdAddr == LAST_COL) begin
                        st_q    <= StFlush;
                        issue_q <= 1'b0;
                        flush_q <= '0;
                    end else begin
                        o_rdAddr <= o_rdAddr + 1'b1;
                    end
                end
                StFlush: begin
                    o_wrEn   <= dl_issue ? run_mask(dl_sub) : '0;
                    o_wrAddr <= dl_addr;
                    if (flush_q == LAST_FLUSH) begin
                        o_rdAddr <= '0;
                        if (o_substate == LAST_SUB) begin
                            st_q       <= StDrain;
                            o_state    <= ST_DRAIN;
                            o_substate <= '0;
                            lat_q      <= '0;
                        end else begin
                            st_q       <= StRun;
                            o_substate <= o_substate + 1'b1;
                            issue_q    <= 1'b1;
                        end
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!o_valid) begin
                        if (lat_q == LAST_LAT) o_valid <= 1'b1;
                        else                   lat_q   <= lat_q + 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        lat_q   <= '0;
                        if (o_rdAddr == LAST_COL) begin
                            o_rdAddr <= '0;
                            if (o_memSelect == LAST_DRAIN_MEM) begin
                                st_q        <= StIdle;
                                o_state     <= ST_LOAD;
                                o_memSelect <= '0;
                                o_done      <= 1'b1;
                            end else begin
                                o_memSelect <= o_memSelect + 1'b1;
                            end
                        end else begin
                            o_rdAddr <= o_rdAddr + 1'b1;
                        end
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule
